// File: rtl/window3x3_stream_pkg.sv
// Shared definitions for the 3x3 window engine: filter modes, FSM encoding
// and the result clamp.
package win3x3_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_BOX  = 2'd1;
    localparam logic [1:0] MODE_LAP  = 2'd2;
    localparam logic [1:0] MODE_MAX  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturate a signed intermediate into the unsigned range [0, 2^dw-1].
    function automatic logic [31:0] clamp(input logic signed [31:0] v, input int unsigned dw);
        logic [31:0] max_v;
        max_v = (32'd1 << dw) - 32'd1;
        if (v < 0)
            return 32'd0;
        else if ($unsigned(v) > max_v)
            return max_v;
        else
            return $unsigned(v);
    endfunction

endpackage

// File: rtl/window3x3_stream_line_buffer.sv
// Single line delay: shifts one pixel per enable, output is the pixel written
// DEPTH enables earlier. Contents are deliberately not reset.
module line_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood engine with mode-selected filter output.
// Optional frame statistics ports are enabled by defining WINDOW3X3_STATS_EN.
//
// state | meaning
// IDLE  | waiting for start, pix_ready low
// RUN   | accepting the frame's pixels
// DONE  | one cycle, complete pulse coincides with the last window
module window3x3_stream
    import win3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_W-1:0]     pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [9*DATA_W-1:0]   win_flat,
    output logic                  win_valid,
    output logic [DATA_W-1:0]     result,
    output logic [CW-1:0]         win_x,
    output logic [RW-1:0]         win_y,
`ifdef WINDOW3X3_STATS_EN
    output logic [DATA_W-1:0]     frame_min,
    output logic [DATA_W-1:0]     frame_max,
`endif
    output logic                  busy,
    output logic                  complete
);

    localparam int ACC_W = DATA_W + 5;

    state_t              state, state_nx;
    logic [CW-1:0]       x;
    logic [RW-1:0]       y;
    logic [1:0]          mode_q;
    logic                accept;
    logic                last_pix;
    logic [DATA_W-1:0]   lb0_q, lb1_q;
    logic [DATA_W-1:0]   col_a [3];
    logic [DATA_W-1:0]   col_b [3];
    logic [DATA_W-1:0]   w [9];
    logic [9*DATA_W-1:0] flat_c;
    logic signed [ACC_W-1:0] sum, w4e, filt;
    logic [DATA_W-1:0]   mx;
    logic signed [31:0]  filt32;

    assign accept   = pix_valid && (state == RUN);
    assign last_pix = accept && (x == CW'(IMG_W-1)) && (y == RW'(IMG_H-1));

    assign pix_ready = (state == RUN);
    assign busy      = (state == RUN);
    assign complete  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_pix) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // lb0 delays the stream by one row, lb1 by two.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
        .clk (clk),
        .en  (accept),
        .din (pix_in),
        .dout(lb0_q)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .clk (clk),
        .en  (accept),
        .din (lb0_q),
        .dout(lb1_q)
    );

    // Two previous columns per row; the incoming column completes the window.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++)
                col_a[r] <= col_b[r];
            col_b[0] <= lb1_q;
            col_b[1] <= lb0_q;
            col_b[2] <= pix_in;
        end
    end

    always_comb begin
        w[0] = col_a[0];
        w[1] = col_b[0];
        w[2] = lb1_q;
        w[3] = col_a[1];
        w[4] = col_b[1];
        w[5] = lb0_q;
        w[6] = col_a[2];
        w[7] = col_b[2];
        w[8] = pix_in;
        flat_c = '0;
        for (int i = 0; i < 9; i++)
            flat_c[DATA_W*i +: DATA_W] = w[i];
    end

    always_comb begin
        sum = '0;
        mx  = w[0];
        for (int i = 0; i < 9; i++) begin
            sum = sum + $signed({5'b0, w[i]});
            if (w[i] > mx)
                mx = w[i];
        end
        w4e = $signed({5'b0, w[4]});
        case (mode_q)
            MODE_PASS: filt = w4e;
            MODE_BOX:  filt = sum >>> 3;
            MODE_LAP:  filt = (w4e <<< 3) - (sum - w4e);
            default:   filt = $signed({5'b0, mx});
        endcase
        filt32 = {{(32-ACC_W){filt[ACC_W-1]}}, filt};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            mode_q    <= MODE_PASS;
            win_valid <= 1'b0;
            win_flat  <= '0;
            result    <= '0;
            win_x     <= '0;
            win_y     <= '0;
        end else begin
            win_valid <= 1'b0;
            if (state == IDLE && start) begin
                x      <= '0;
                y      <= '0;
                mode_q <= mode;
            end
            if (accept) begin
                if (x == CW'(IMG_W-1)) begin
                    x <= '0;
                    y <= (y == RW'(IMG_H-1)) ? '0 : y + RW'(1);
                end else begin
                    x <= x + CW'(1);
                end
                // Windows only form once two full columns and rows are behind us.
                if (x >= CW'(2) && y >= RW'(2)) begin
                    win_valid <= 1'b1;
                    win_flat  <= flat_c;
                    result    <= DATA_W'(clamp(filt32, DATA_W));
                    win_x     <= x - CW'(1);
                    win_y     <= y - RW'(1);
                end
            end
        end
    end

`ifdef WINDOW3X3_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_min <= '0;
            frame_max <= '0;
        end else if (state == IDLE && start) begin
            frame_min <= '1;
            frame_max <= '0;
        end else if (accept) begin
            if (pix_in < frame_min) frame_min <= pix_in;
            if (pix_in > frame_max) frame_max <= pix_in;
        end
    end
`endif

endmodule
